// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 holding demultiplexer.
//   WIDTH_DEF : default data width of the input word and each output slot
//   NUM_OUT   : number of destination slots
//   sel_t     : slot-select index type (0..NUM_OUT-1)
package demux_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NUM_OUT   = 4;

  typedef logic [1:0] sel_t;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with a valid flag.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   load         : capture load_data this edge and mark the slot full
//   load_data    : word to capture
//   drain        : consumer takes the held word this edge
//   valid        : slot holds an undelivered word
//   data         : held word; keeps its last value after being drained
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load wins over drain, so a same-edge drain and reload keeps the slot full
  // with the new word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every slot and
      // the counter update from the same pre-edge values.
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the data register is deliberately reset; held words must read as
  // zero during reset, not just be invalidated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/demux64x1_4.sv
// demux64x1_4: routes an offered word into one of four one-entry holding slots.
// Optional macro DEMUX_BCAST_EN adds in_bcast, which loads all four slots.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   in_data      : word to route            in_sel    : destination slot 0..3
//   in_valid     : word offered             in_ready  : word accepted this cycle
//   in_bcast     : (DEMUX_BCAST_EN only) route the word to every slot
//   out_data     : held word of slot i at [i*WIDTH +: WIDTH]
//   out_valid    : slot i holds an undelivered word
//   out_ready    : consumer i takes its slot this cycle
//   xfer_count   : number of accepted input words, wraps at 2^32
module demux64x1_4
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef DEMUX_BCAST_EN
  input  logic                   in_bcast,
`endif
  input  logic [WIDTH-1:0]       in_data,
  input  sel_t                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]     out_valid,
  input  logic [NUM_OUT-1:0]     out_ready,
  output logic [31:0]            xfer_count
);

  logic [NUM_OUT-1:0] slot_free;   // empty, or being drained this cycle
  logic [NUM_OUT-1:0] load;
  logic               accept;

  assign slot_free = ~out_valid | out_ready;

  // in_ready depends only on slot state and the select, never on in_valid.
`ifdef DEMUX_BCAST_EN
  assign in_ready = in_bcast ? (&slot_free) : slot_free[in_sel];
`else
  assign in_ready = slot_free[in_sel];
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    // NOTE: default first so every path assigns load and no latch is inferred.
    load = '0;
`ifdef DEMUX_BCAST_EN
    if (accept && in_bcast) begin
      load = '1;
    end else if (accept) begin
      load[in_sel] = 1'b1;
    end
`else
    if (accept) begin
      load[in_sel] = 1'b1;
    end
`endif
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load[i]),
      .load_data (in_data),
      .drain     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*WIDTH +: WIDTH])
    );
  end

  // One count per accepted word, broadcast included; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_demux64x1_4.sv
// tb_demux64x1_4: self-checking bench for demux64x1_4 (default WIDTH = 64).
// A behavioural slot model is compared with the DUT on every falling edge;
// directed literal checks pin the model at the interesting points.
// Define DEMUX_BCAST_EN to exercise the broadcast option as well.
module tb_demux64x1_4;

  localparam int W = 64;

  logic           clk;
  logic           reset_n;
  logic           bcast;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [31:0]    xfer_count;

  int checks = 0;
  int errors = 0;

  demux64x1_4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef DEMUX_BCAST_EN
    .in_bcast   (bcast),
`endif
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_data [4];
  bit           m_full [4];
  logic [31:0]  m_count;
  bit           m_acc;

  function automatic bit model_ready();
    bit all_free = 1'b1;
    for (int i = 0; i < 4; i++)
      if (m_full[i] && !out_ready[i]) all_free = 1'b0;
    if (bcast) return all_free;
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = '0;
      end
      m_count = 0;
    end else begin
      m_acc = in_valid && model_ready();
      for (int i = 0; i < 4; i++) begin
        if (m_acc && (bcast || in_sel == i)) begin
          m_full[i] = 1'b1;
          m_data[i] = in_data;
        end else if (out_ready[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (m_acc) m_count = m_count + 1;
    end
  end

  // Compare process: outputs are meaningful on every cycle, reset included.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cmp out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_full[i]));
      check($sformatf("cmp out_data[%0d]", i), out_data[i*W +: W], m_data[i]);
    end
    check("cmp xfer_count", 64'(xfer_count), 64'(m_count));
    check("cmp in_ready", 64'(in_ready), 64'(model_ready()));
  end

  // Apply one cycle of stimulus shortly after a rising edge.
  task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] r);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    reset_n   = 1'b0;
    bcast     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;

    // Reset state
    #12;
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data0", out_data[0 +: W], 64'h0);
    check("reset out_data3", out_data[3*W +: W], 64'h0);
    check("reset xfer_count", 64'(xfer_count), 64'h0);
    check("reset in_ready", 64'(in_ready), 64'h1);
    #5 reset_n = 1'b1;

    // Routing to all four slots, no consumers ready
    drive(1, 2'd0, 64'hF00D, 4'b0000);
    drive(1, 2'd1, 64'hDADA, 4'b0000);
    @(negedge clk);
    check("route latency slot0", out_data[0 +: W], 64'hF00D);
    check("route latency valid", 64'(out_valid), 64'h1);
    drive(1, 2'd2, 64'hFFFF, 4'b0000);
    drive(1, 2'd3, 64'hDEAD, 4'b0000);
    drive(0, 2'd0, 64'h5555, 4'b0000);   // ignored: in_valid low
    @(negedge clk);
    check("route out_valid", 64'(out_valid), 64'hF);
    check("route slot1", out_data[1*W +: W], 64'hDADA);
    check("route slot2", out_data[2*W +: W], 64'hFFFF);
    check("route slot3", out_data[3*W +: W], 64'hDEAD);
    check("route xfer_count", 64'(xfer_count), 64'd4);

    // Backpressure on full slot 2
    drive(1, 2'd2, 64'h1111, 4'b0000);
    @(negedge clk);
    check("bp in_ready", 64'(in_ready), 64'h0);
    drive(0, 2'd0, 64'h0, 4'b0000);
    @(negedge clk);
    check("bp slot2 held", out_data[2*W +: W], 64'hFFFF);
    check("bp xfer_count", 64'(xfer_count), 64'd4);

    // Same-slot drain and load
    drive(1, 2'd1, 64'hBEEF, 4'b0010);
    @(negedge clk);
    check("ld+drain in_ready", 64'(in_ready), 64'h1);
    drive(0, 2'd0, 64'h0, 4'b0000);
    @(negedge clk);
    check("ld+drain valid1", 64'(out_valid[1]), 64'h1);
    check("ld+drain slot1", out_data[1*W +: W], 64'hBEEF);
    check("ld+drain xfer", 64'(xfer_count), 64'd5);

    // Parallel drains of slots 0 and 3; data held after drain
    drive(0, 2'd3, 64'h7777, 4'b1001);
    drive(0, 2'd0, 64'h0, 4'b0000);
    @(negedge clk);
    check("drain out_valid", 64'(out_valid), 64'b0110);
    check("drain slot0 held", out_data[0 +: W], 64'hF00D);

    // Reset mid-operation, asynchronous
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'h0);
    check("async rst slot1", out_data[1*W +: W], 64'h0);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 64'hA5;
    @(posedge clk);
    #3;
    check("rst hold xfer", 64'(xfer_count), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("post rst xfer", 64'(xfer_count), 64'd1);
    check("post rst valid", 64'(out_valid), 64'b0001);
    check("post rst slot0", out_data[0 +: W], 64'hA5);

`ifdef DEMUX_BCAST_EN
    // Broadcast blocked while slot 0 is full and not draining
    drive(1, 2'd2, 64'h9999, 4'b0000);
    bcast = 1'b1;
    @(negedge clk);
    check("bcast blocked", 64'(in_ready), 64'h0);
    drive(0, 2'd0, 64'h0, 4'b0000);
    bcast = 1'b0;
    // Fresh reset, then broadcast into empty slots
    @(posedge clk);
    #3 reset_n = 1'b0;
    #4 reset_n = 1'b1;
    drive(1, 2'd0, 64'h1234, 4'b0000);
    bcast = 1'b1;
    drive(0, 2'd0, 64'h0, 4'b0000);
    bcast = 1'b0;
    @(negedge clk);
    check("bcast out_valid", 64'(out_valid), 64'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("bcast slot%0d", i), out_data[i*W +: W], 64'h1234);
    check("bcast xfer_count", 64'(xfer_count), 64'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux64x1_4.md
DEMUX64X1_4 -- requirements
Module: demux64x1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data width of the input and each output.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock, rising-edge active.
REQ-003 SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits, meaning the source word to route.
REQ-005 SHALL have port in_sel, input, 2 bits, meaning the destination slot index 0..3.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data and in_sel are offered.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the offered word is accepted this cycle.
REQ-008 SHALL have port out_data, output, 4 x WIDTH bits, meaning the held word of each slot.
REQ-009 SHALL have port out_valid, output, 4 bits, meaning each slot holds an undelivered word.
REQ-010 SHALL have port out_ready, input, 4 bits, meaning each consumer takes its slot this cycle.
REQ-011 SHALL have port xfer_count, output, 32 bits, meaning the number of accepted input words.

Function
REQ-012 SHALL contain four one-entry holding slots, each with a valid flag and a WIDTH-bit data register.
REQ-013 SHALL drive in_ready = ~out_valid[in_sel] | out_ready[in_sel], independent of in_valid.
REQ-014 SHALL accept a word when in_valid & in_ready are both high at a rising clk edge.
REQ-015 SHALL load in_data into slot in_sel and set its valid flag on the accepting edge, giving 1-cycle latency.
REQ-016 SHALL clear a slot's valid flag on an edge where out_valid[i] & out_ready[i] and no load targets slot i.
REQ-017 SHALL, on a simultaneous drain and load of the same slot, keep valid high and hold the new word.
REQ-018 SHALL leave unselected slots unaffected by a load; drains of different slots proceed in parallel.
REQ-019 SHALL hold out_data[i] at its last value while out_valid[i] is low.
REQ-020 SHALL have no combinational path from in_data or in_sel to out_data or out_valid.
REQ-021 SHALL ignore in_data and in_sel while in_valid is low.
REQ-022 SHALL increment xfer_count by 1 per accepted word, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-023 SHALL, while reset_n is low, force out_valid to 0, every out_data slot to 0 and xfer_count to 0, asynchronously.
REQ-024 SHALL discard all held words when reset asserts mid-operation; no word is delivered after reset.
REQ-025 SHALL accept a new word no earlier than the first rising clk edge after reset_n deasserts.

Configuration
REQ-026 SHALL, when macro DEMUX_BCAST_EN is defined, add a 1-bit input in_bcast.
REQ-027 SHALL, with DEMUX_BCAST_EN defined and in_bcast high, drive in_ready high only when every slot is empty or draining.
REQ-028 SHALL, with DEMUX_BCAST_EN defined, load in_data into all four slots on a broadcast accept and increment xfer_count by 1.
REQ-029 SHALL, without DEMUX_BCAST_EN, have no in_bcast port and route to in_sel only.

Structure
REQ-030 SHALL take WIDTH default, NUM_OUT = 4 and a 2-bit slot-select typedef from shared package demux_pkg.
REQ-031 SHALL implement each slot as sub-module demux_slot, holding one word with load, drain and valid, instantiated four times.

Verification
REQ-032 SHALL check reset: reset_n low -> out_valid = 4'b0000, out_data all zero, xfer_count = 0, in_ready = 1.
REQ-033 SHALL check routing:
- Stimulus: in_data 0xF00D/0xDADA/0xFFFF/0xDEAD with in_sel 0/1/2/3 on consecutive cycles, out_ready = 0.
- Response: each slot holds its word one cycle after acceptance, out_valid = 4'b1111, xfer_count = 4.
REQ-034 SHALL check backpressure: slot 2 full with out_ready[2] = 0 and in_sel = 2 -> in_ready = 0, slot 2 keeps 0xFFFF, xfer_count unchanged.
REQ-035 SHALL check same-slot load and drain: slot 1 holds 0xDADA, out_ready[1] = 1, load 0xBEEF to slot 1 -> out_valid[1] stays 1, out_data[1] = 0xBEEF.
REQ-036 SHALL check reset mid-operation: reset_n pulsed low with slots full -> out_valid = 0 immediately without a clock edge, and the next accepted word counts as xfer_count = 1.
REQ-037 SHALL, with DEMUX_BCAST_EN defined, check broadcast: in_bcast = 1 with 0x1234 and all slots empty -> all four slots = 0x1234, xfer_count = 1.
